// File: rtl/hack_pkg.sv
// Shared definitions for the Hack boot loader: ROM geometry, loader FSM states, error codes.
// No logic; no latency; no backpressure.
// Imported by rom_loader and its sub-modules.
package hack_pkg;

    localparam int HACK_ROM_DEPTH = 32768;
    localparam int HACK_ADDR_W    = 15;

    localparam logic [1:0] LOAD_ERR_NONE    = 2'd0;
    localparam logic [1:0] LOAD_ERR_LEN     = 2'd1;
    localparam logic [1:0] LOAD_ERR_SUM     = 2'd2;
    localparam logic [1:0] LOAD_ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_SUM_HI  = 4'd5,
        ST_SUM_LO  = 4'd6,
        ST_RUN     = 4'd7,
        ST_ERROR   = 4'd8
    } loader_state_t;

    // Receiving states are the only ones that accept bytes or run the idle timer.
    function automatic logic is_rx_state(input loader_state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_SUM_HI) || (s == ST_SUM_LO);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter: expired asserts once TIMEOUT_CYCLES enabled cycles pass without clr.
// Latency: expired is combinational from the count; clr takes effect next cycle.
// No backpressure; TIMEOUT_CYCLES = 0 disables expiry.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count T-1 holds in the cycle before the T-th edge, so the FSM leaves exactly T cycles after the last clear.
    assign expired = (TIMEOUT_CYCLES != 0) && en &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: length-prefixed big-endian word stream with 16-bit checksum into the instruction ROM.
// Latency: ROM write one cycle after the low-byte acceptance; done one cycle after checksum acceptance.
// Backpressure: rx_ready is high only in receiving states; the CPU is held in reset until a verified load.
module rom_loader
    import hack_pkg::*;
#(
    parameter int DEPTH          = HACK_ROM_DEPTH,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int HOLD_AT_RESET  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   rom_we,
    output logic [HACK_ADDR_W-1:0] rom_addr,
    output logic [15:0]            rom_wdata,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             error_code
);

    loader_state_t          state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [7:0]             hi_q, hi_d;
    logic [7:0]             sum_hi_q, sum_hi_d;
    logic [15:0]            sum_q, sum_d;
    logic [HACK_ADDR_W-1:0] idx_q, idx_d;
    logic                   we_q, we_d;
    logic [HACK_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic [1:0]             err_q, err_d;

    logic        accept;
    logic        tmr_clr;
    logic        tmr_expired;
    logic [15:0] len_new;
    logic [15:0] word_new;

    assign busy     = is_rx_state(state_q);
    assign rx_ready = busy;
    assign accept   = rx_valid && rx_ready;
    assign len_new  = {len_q[15:8], rx_data};
    assign word_new = {hi_q, rx_data};

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .en      (busy),
        .clr     (tmr_clr),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        hi_d     = hi_q;
        sum_hi_d = sum_hi_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = err_q;
        tmr_clr  = accept;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = LOAD_ERR_NONE;
                    tmr_clr = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = len_new;
                    if ((len_new == 16'd0) || ({16'd0, len_new} > 32'(DEPTH))) begin
                        state_d = ST_ERROR;
                        err_d   = LOAD_ERR_LEN;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = word_new;
                    sum_d   = sum_q + word_new;
                    if ({1'b0, idx_q} == (len_q - 16'd1)) begin
                        state_d = ST_SUM_HI;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_SUM_HI: begin
                if (accept) begin
                    sum_hi_d = rx_data;
                    state_d  = ST_SUM_LO;
                end
            end
            ST_SUM_LO: begin
                if (accept) begin
                    if ({sum_hi_q, rx_data} == sum_q) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = LOAD_ERR_SUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte accepted on the expiry cycle keeps the load alive.
        if (busy && !accept && tmr_expired) begin
            state_d = ST_ERROR;
            err_d   = LOAD_ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= (HOLD_AT_RESET != 0) ? ST_IDLE : ST_RUN;
            len_q    <= '0;
            hi_q     <= '0;
            sum_hi_q <= '0;
            sum_q    <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= LOAD_ERR_NONE;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            sum_hi_q <= sum_hi_d;
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rom_we     = we_q;
    assign rom_addr   = addr_q;
    assign rom_wdata  = wdata_q;
    assign done       = done_q;
    assign error_code = err_q;
    // Reset is ORed in so the CPU stays held even when reset parks the FSM in RUN.
    assign cpu_reset  = reset || (state_q != ST_RUN);

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus queues expected ROM writes, a negedge monitor checks them.
module tb_rom_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic [1:0]  error_code;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    logic [30:0] exp_q[$];

    logic [7:0] stim[10];
    int         gaps[10] = '{0, 3, 1, 15, 2, 0, 5, 1, 4, 2};

    always #5 clock = ~clock;

    rom_loader #(
        .DEPTH          (32768),
        .TIMEOUT_CYCLES (16),
        .HOLD_AT_RESET  (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error_code (error_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every observed ROM write must match the head of the expected queue.
    always @(negedge clock) begin
        if (rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", rom_addr, rom_wdata);
            end else begin
                check("rom_write", {1'b0, rom_addr, rom_wdata}, {1'b0, exp_q.pop_front()});
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clock);
        if (gap > 0) #1;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL rx_ready_wait: byte 0x%0h not accepted within 50 cycles", b);
            rx_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic set_stream(input logic [7:0] sum_lo);
        stim = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hBE, sum_lo};
    endtask

    // Full 3-word load; exp_code 0 means checksum good (BE02), 2 means mismatch.
    task automatic run_load(input logic [7:0] sum_lo, input bit use_gaps, input logic [1:0] exp_code);
        int d0;
        set_stream(sum_lo);
        exp_q.push_back({15'd0, 16'h1234});
        exp_q.push_back({15'd1, 16'hABCD});
        exp_q.push_back({15'd2, 16'h0001});
        d0 = done_cnt;
        do_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) send_byte(stim[i], use_gaps ? gaps[i] : 0);
        repeat (3) @(posedge clock);
        #1;
        check("load_error_code", {30'd0, error_code}, {30'd0, exp_code});
        check("load_cpu_reset", {31'd0, cpu_reset}, (exp_code == 2'd0) ? 32'd0 : 32'd1);
        check("load_busy", {31'd0, busy}, 32'd0);
        check("load_done_pulses", done_cnt - d0, (exp_code == 2'd0) ? 32'd1 : 32'd0);
        check("load_writes_seen", exp_q.size(), 32'd0);
    endtask

    task automatic bad_len(input logic [7:0] lhi, input logic [7:0] llo);
        do_start();
        send_byte(lhi, 0);
        send_byte(llo, 0);
        repeat (2) @(posedge clock);
        #1;
        check("badlen_error_code", {30'd0, error_code}, 32'd1);
        check("badlen_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("badlen_rx_ready", {31'd0, rx_ready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rom_we", {31'd0, rom_we}, 32'd0);
        check("rst_rom_addr", {17'd0, rom_addr}, 32'd0);
        check("rst_rom_wdata", {16'd0, rom_wdata}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error_code", {30'd0, error_code}, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

        // Normal load, continuous valid.
        run_load(8'h02, 1'b0, 2'd0);
        // Gapped valid, including one byte landing exactly on the expiry edge.
        run_load(8'h02, 1'b1, 2'd0);
        // Checksum mismatch.
        run_load(8'h03, 1'b0, 2'd2);

        // Bad lengths: zero and DEPTH+1, then recovery.
        bad_len(8'h00, 8'h00);
        bad_len(8'h80, 8'h01);
        run_load(8'h02, 1'b0, 2'd0);

        // Timeout: stall after 00 03 12; ERROR exactly 16 cycles after last acceptance.
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h12, 0);
        repeat (15) @(posedge clock);
        #1;
        check("tmo_not_yet", {30'd0, error_code}, 32'd0);
        check("tmo_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        check("tmo_error_code", {30'd0, error_code}, 32'd3);
        check("tmo_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("tmo_busy_after", {31'd0, busy}, 32'd0);

        // Reset asserted during the second word's write pulse.
        exp_q.push_back({15'd0, 16'h1234});
        set_stream(8'h02);
        do_start();
        for (int i = 0; i < 6; i++) send_byte(stim[i], 0);
        reset = 1'b1;
        #1;
        check("midrst_rom_we", {31'd0, rom_we}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("postrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("postrst_error_code", {30'd0, error_code}, 32'd0);
        run_load(8'h02, 1'b0, 2'd0);

        repeat (3) @(posedge clock);
        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
